iterative_divider: RTL and testbench



---
 rtl/iterative_divider_pkg.sv | 14 +
 rtl/fast_adder.sv | 53 +++++
 rtl/iterative_divider.sv | 146 ++++++++++++++
 tb/tb_iterative_divider.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/iterative_divider_pkg.sv
// Shared types and sizing helpers for the iterative restoring divider.
package iterative_divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

  function automatic int div_cnt_width(input int bit_width);
    return $clog2(bit_width);
  endfunction

endpackage

// File: rtl/fast_adder.sv
// Grouped carry-lookahead adder: S = A + B + C_IN, combinational, no backpressure.
// P/G expose the per-bit propagate/generate terms for callers that chain adders.
module fast_adder #(
  parameter int bit_width    = 8,
  parameter int cascade_size = 4
) (
  input  logic [bit_width-1:0] A,
  input  logic [bit_width-1:0] B,
  input  logic                 C_IN,
  output logic [bit_width-1:0] S,
  output logic                 C_OUT,
  output logic [bit_width-1:0] P,
  output logic [bit_width-1:0] G
);

  logic [bit_width-1:0] prop;
  logic [bit_width-1:0] gen;
  logic [bit_width:0]   carry;
  logic                 grp_g;
  logic                 grp_p;
  logic                 grp_cin;

  assign prop = A ^ B;
  assign gen  = A & B;

  // Inside a group carries ripple; each group's carry-out is formed from the
  // group generate/propagate terms so the inter-group path stays short.
  always_comb begin
    carry    = '0;
    carry[0] = C_IN;
    grp_g    = 1'b0;
    grp_p    = 1'b1;
    grp_cin  = C_IN;
    for (int i = 0; i < bit_width; i++) begin
      grp_g = gen[i] | (prop[i] & grp_g);
      grp_p = grp_p & prop[i];
      if (((i + 1) % cascade_size == 0) || (i == bit_width - 1)) begin
        carry[i+1] = grp_g | (grp_p & grp_cin);
        grp_cin    = carry[i+1];
        grp_g      = 1'b0;
        grp_p      = 1'b1;
      end else begin
        carry[i+1] = gen[i] | (prop[i] & carry[i]);
      end
    end
  end

  assign S     = prop ^ carry[bit_width-1:0];
  assign C_OUT = carry[bit_width];
  assign P     = prop;
  assign G     = gen;

endmodule

// File: rtl/iterative_divider.sv
// Restoring divider, one quotient bit per clock; signed operands when ITERATIVE_DIVIDER_SIGNED_EN is defined.
// Latency: bit_width edges from request handshake to OUT_VALID (divide-by-zero: result valid right after handshake).
// Backpressure: result held stable while OUT_READY=0; IN_READY only in IDLE, no same-cycle re-accept.
module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int bit_width    = 8,
  parameter int cascade_size = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [bit_width-1:0] DIVIDEND,
  input  logic [bit_width-1:0] DIVISOR,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [bit_width-1:0] QUOTIENT,
  output logic [bit_width-1:0] REMAINDER,
  output logic                 DIV_ZERO
);

  localparam int CW = div_cnt_width(bit_width);

  div_state_t           state;
  logic [CW-1:0]        cnt;
  logic [bit_width-1:0] p;
  logic [bit_width-1:0] dvd;
  logic [bit_width-1:0] dvs;
  logic [bit_width-1:0] q;
  logic [bit_width:0]   trial;
  logic [bit_width:0]   diff;
  logic                 no_borrow;
  logic                 diff_msb_unused;
  logic [bit_width-1:0] q_next;
  logic [bit_width-1:0] r_next;
  logic [bit_width-1:0] q_fin;
  logic [bit_width-1:0] r_fin;
  logic [bit_width-1:0] dvd_in;
  logic [bit_width-1:0] dvs_in;

  // The partial remainder always stays below the divisor, so bit_width bits
  // hold it; the extra trial bit only matters for the subtract itself.
  assign trial = {p, dvd[bit_width-1]};

  fast_adder #(
    .bit_width   (bit_width + 1),
    .cascade_size(cascade_size)
  ) u_sub (
    .A    (trial),
    .B    (~{1'b0, dvs}),
    .C_IN (1'b1),
    .S    (diff),
    .C_OUT(no_borrow),
    .P    (),
    .G    ()
  );

  assign diff_msb_unused = diff[bit_width];
  assign q_next          = {q[bit_width-2:0], no_borrow};
  assign r_next          = no_borrow ? diff[bit_width-1:0] : trial[bit_width-1:0];

`ifdef ITERATIVE_DIVIDER_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // Most-negative operand maps to itself, which is its correct unsigned magnitude.
  assign dvd_in = DIVIDEND[bit_width-1] ? -DIVIDEND : DIVIDEND;
  assign dvs_in = DIVISOR[bit_width-1]  ? -DIVISOR  : DIVISOR;
  assign q_fin  = neg_q ? -q_next : q_next;
  assign r_fin  = neg_r ? -r_next : r_next;
`else
  assign dvd_in = DIVIDEND;
  assign dvs_in = DIVISOR;
  assign q_fin  = q_next;
  assign r_fin  = r_next;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      p         <= '0;
      dvd       <= '0;
      dvs       <= '0;
      q         <= '0;
      IN_READY  <= 1'b1;
      OUT_VALID <= 1'b0;
      QUOTIENT  <= '0;
      REMAINDER <= '0;
      DIV_ZERO  <= 1'b0;
`ifdef ITERATIVE_DIVIDER_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            IN_READY <= 1'b0;
            if (DIVISOR == '0) begin
              state     <= DONE;
              OUT_VALID <= 1'b1;
              QUOTIENT  <= '1;
              REMAINDER <= DIVIDEND;
              DIV_ZERO  <= 1'b1;
            end else begin
              state    <= BUSY;
              cnt      <= CW'(bit_width - 1);
              p        <= '0;
              q        <= '0;
              dvd      <= dvd_in;
              dvs      <= dvs_in;
              DIV_ZERO <= 1'b0;
`ifdef ITERATIVE_DIVIDER_SIGNED_EN
              neg_q    <= DIVIDEND[bit_width-1] ^ DIVISOR[bit_width-1];
              neg_r    <= DIVIDEND[bit_width-1];
`endif
            end
          end
        end
        BUSY: begin
          p   <= r_next;
          q   <= q_next;
          dvd <= {dvd[bit_width-2:0], 1'b0};
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state     <= DONE;
            OUT_VALID <= 1'b1;
            QUOTIENT  <= q_fin;
            REMAINDER <= r_fin;
          end
        end
        DONE: begin
          if (OUT_READY) begin
            state     <= IDLE;
            OUT_VALID <= 1'b0;
            IN_READY  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// Directed bench for iterative_divider at bit_width=8: results, latency, backpressure, async reset.
module tb_iterative_divider;

  logic       CLK = 1'b0;
  logic       RST;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] DIVIDEND;
  logic [7:0] DIVISOR;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [7:0] QUOTIENT;
  logic [7:0] REMAINDER;
  logic       DIV_ZERO;

  int errors = 0;
  int checks = 0;

  iterative_divider #(
    .bit_width   (8),
    .cascade_size(4)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .DIVIDEND (DIVIDEND),
    .DIVISOR  (DIVISOR),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .QUOTIENT (QUOTIENT),
    .REMAINDER(REMAINDER),
    .DIV_ZERO (DIV_ZERO)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered and left at #1 after a rising edge with the DUT idle and OUT_READY=1.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er, input logic ez,
                       input int elat);
    int lat;
    chk({tag, ".in_ready_idle"}, 32'(IN_READY), 32'd1);
    IN_VALID = 1'b1;
    DIVIDEND = a;
    DIVISOR  = b;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    chk({tag, ".in_ready_busy"}, 32'(IN_READY), 32'd0);
    lat = 0;
    while (!OUT_VALID && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(elat));
    chk({tag, ".quotient"}, 32'(QUOTIENT), 32'(eq));
    chk({tag, ".remainder"}, 32'(REMAINDER), 32'(er));
    chk({tag, ".div_zero"}, 32'(DIV_ZERO), 32'(ez));
    @(posedge CLK); #1;
    chk({tag, ".out_valid_drop"}, 32'(OUT_VALID), 32'd0);
    chk({tag, ".in_ready_back"}, 32'(IN_READY), 32'd1);
  endtask

  initial begin
    int lat;
    RST       = 1'b1;
    IN_VALID  = 1'b0;
    DIVIDEND  = '0;
    DIVISOR   = '0;
    OUT_READY = 1'b1;
    #2;
    chk("reset.in_ready", 32'(IN_READY), 32'd1);
    chk("reset.out_valid", 32'(OUT_VALID), 32'd0);
    chk("reset.quotient", 32'(QUOTIENT), 32'd0);
    chk("reset.remainder", 32'(REMAINDER), 32'd0);
    chk("reset.div_zero", 32'(DIV_ZERO), 32'd0);
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

`ifdef ITERATIVE_DIVIDER_SIGNED_EN
    do_op("n56_7", 8'd200, 8'd7, 8'hF8, 8'h00, 1'b0, 8);
`else
    do_op("200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 8);
`endif
    do_op("5_0", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 0);
    do_op("0_1", 8'd0, 8'd1, 8'd0, 8'd0, 1'b0, 8);
    do_op("255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 8);
    do_op("255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8);
    do_op("7_9", 8'd7, 8'd9, 8'd0, 8'd7, 1'b0, 8);

    // Backpressure: hold the result five cycles, with a stray request pulse.
    OUT_READY = 1'b0;
    IN_VALID  = 1'b1;
    DIVIDEND  = 8'd100;
    DIVISOR   = 8'd3;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    lat = 0;
    while (!OUT_VALID && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
    chk("bp.latency", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      chk("bp.out_valid", 32'(OUT_VALID), 32'd1);
      chk("bp.quotient", 32'(QUOTIENT), 32'd33);
      chk("bp.remainder", 32'(REMAINDER), 32'd1);
      chk("bp.in_ready", 32'(IN_READY), 32'd0);
      IN_VALID = (i == 1);
      DIVIDEND = 8'd9;
      DIVISOR  = 8'd9;
      @(posedge CLK); #1;
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    chk("bp.release_out_valid", 32'(OUT_VALID), 32'd0);
    chk("bp.release_in_ready", 32'(IN_READY), 32'd1);
    chk("bp.quotient_hold", 32'(QUOTIENT), 32'd33);
    @(posedge CLK); #1;
    chk("bp.stray_ignored", 32'(OUT_VALID), 32'd0);

    // Asynchronous reset three cycles into an operation.
    IN_VALID = 1'b1;
    DIVIDEND = 8'd200;
    DIVISOR  = 8'd7;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (3) begin
      @(posedge CLK); #1;
    end
    chk("rst_mid.in_ready_before", 32'(IN_READY), 32'd0);
    RST = 1'b1;
    #2;
    chk("rst_mid.in_ready", 32'(IN_READY), 32'd1);
    chk("rst_mid.out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_mid.quotient", 32'(QUOTIENT), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    do_op("50_5", 8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 8);

`ifdef ITERATIVE_DIVIDER_SIGNED_EN
    do_op("m7_2", 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 8);
    do_op("7_m2", 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 8);
    do_op("m128_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 8);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach summary, errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
